// File: rtl/axis_byte_serializer.sv
// axis_byte_serializer: unpacks keep-qualified AXI4-Stream words into a byte stream with per-frame length status.
module axis_byte_serializer #(
  parameter int S_DATA_WIDTH = 32,
  parameter int S_KEEP_WIDTH = S_DATA_WIDTH / 8,
  parameter int USER_WIDTH   = 1,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  output logic [7:0]              m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  output logic [LEN_WIDTH-1:0]    status_frame_len,
  output logic                    status_frame_done,
  output logic                    status_keep_error
);
  localparam int K = S_KEEP_WIDTH;
  logic [S_DATA_WIDTH-1:0] hold_data, cur_data;
  logic                    hold_last, cur_last;
  logic [USER_WIDTH-1:0]   hold_user, cur_user, user_eff;
  logic [K-1:0]            rem, keep_eff, cur_rem, low;
  logic [LEN_WIDTH-1:0]    cnt, cnt_inc;
  logic [7:0]              lane_byte;
  logic                    out_free, rem_zero, one_rem, one_cur, accept, emit, out_hs;
  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign rem_zero = rem == '0;
  assign one_rem  = !rem_zero && (rem & (rem - K'(1))) == '0;
  assign s_axis_tready = rem_zero || (one_rem && out_free);
  assign accept   = s_axis_tvalid && s_axis_tready;
  // An empty-keep closing word still has to carry tlast, so it becomes a flagged lane-0 byte.
  assign keep_eff = s_axis_tkeep != '0 ? s_axis_tkeep : K'(s_axis_tlast);
  assign user_eff = s_axis_tkeep != '0 ? s_axis_tuser : s_axis_tuser | USER_WIDTH'(1);
  // With nothing held, the incoming word feeds the output directly so its first byte lands next cycle.
  assign cur_rem  = !rem_zero ? rem : accept ? keep_eff : '0;
  assign cur_data = rem_zero ? s_axis_tdata : hold_data;
  assign cur_last = rem_zero ? s_axis_tlast : hold_last;
  assign cur_user = rem_zero ? user_eff : hold_user;
  assign low      = cur_rem & (~cur_rem + K'(1));
  assign one_cur  = cur_rem != '0 && cur_rem == low;
  assign emit     = out_free && cur_rem != '0;
  assign out_hs   = m_axis_tvalid && m_axis_tready;
  assign cnt_inc  = &cnt ? cnt : cnt + LEN_WIDTH'(1);
  always_comb begin
    lane_byte = '0;
    for (int i = 0; i < K; i++) lane_byte |= low[i] ? cur_data[8*i +: 8] : 8'h00;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data         <= '0;
      hold_last         <= 1'b0;
      hold_user         <= '0;
      rem               <= '0;
      cnt               <= '0;
      m_axis_tdata      <= '0;
      m_axis_tvalid     <= 1'b0;
      m_axis_tlast      <= 1'b0;
      m_axis_tuser      <= '0;
      status_frame_len  <= '0;
      status_frame_done <= 1'b0;
      status_keep_error <= 1'b0;
    end else begin
      if (accept) begin
        hold_data <= s_axis_tdata;
        hold_last <= s_axis_tlast;
        hold_user <= user_eff;
      end
      rem <= (accept && !rem_zero) ? keep_eff : emit ? cur_rem & ~low : cur_rem;
      if (emit) begin
        m_axis_tdata  <= lane_byte;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= cur_last && one_cur;
        m_axis_tuser  <= (cur_last && one_cur) ? cur_user : '0;
      end else if (out_free) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
        m_axis_tuser  <= '0;
      end
      status_keep_error <= accept && s_axis_tkeep == '0;
      status_frame_done <= out_hs && m_axis_tlast;
      if (out_hs) cnt <= m_axis_tlast ? '0 : cnt_inc;
      if (out_hs && m_axis_tlast) status_frame_len <= cnt_inc;
    end
  end
endmodule

// File: tb/tb_axis_byte_serializer.sv
// tb_axis_byte_serializer: randomized and directed checks of the byte serializer against a queue-based byte model.
module tb_axis_byte_serializer;
  localparam int DW = 32, KW = 4, UW = 1, LW = 16;
  logic clk = 0, rst = 1;
  logic [DW-1:0] s_data = '0;
  logic [KW-1:0] s_keep = '0;
  logic s_valid = 0, s_ready, s_last = 0;
  logic [UW-1:0] s_user = '0;
  logic [7:0] m_data;
  logic m_valid, m_ready = 1, m_last;
  logic [UW-1:0] m_user;
  logic [LW-1:0] f_len;
  logic f_done, k_err;

  axis_byte_serializer #(.S_DATA_WIDTH(DW), .S_KEEP_WIDTH(KW), .USER_WIDTH(UW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tlast(m_last),
    .m_axis_tuser(m_user),
    .status_frame_len(f_len), .status_frame_done(f_done), .status_keep_error(k_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int rmode = 0, pat = 0;
  logic [9:0] exp_q[$], log_q[$], prev_out;
  int hs_cyc[$];
  int model_cnt = 0, exp_len = 0, done_cnt = 0, kerr_cnt = 0, last_len = 0;
  bit exp_done = 0, exp_kerr = 0, prev_stall = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rmode == 0) m_ready = 1;
    else if (rmode == 1) m_ready = $urandom_range(0, 3) != 0;
    else begin
      m_ready = (pat % 3) == 0;
      pat++;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: a word becomes its kept bytes in lane order; tlast/tuser ride only on the final byte.
  task automatic expand(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input logic [UW-1:0] u);
    logic [7:0] b[$];
    logic [UW-1:0] uu;
    uu = u;
    for (int i = 0; i < KW; i++) if (k[i]) b.push_back(d[8*i +: 8]);
    if (k == '0 && l) begin
      b.push_back(d[7:0]);
      uu = u | UW'(1);
    end
    for (int j = 0; j < b.size(); j++) begin
      automatic logic lst = l && (j == b.size() - 1);
      exp_q.push_back({lst ? uu : UW'(0), lst, b[j]});
    end
  endtask

  always @(negedge clk) begin
    int pend;
    logic [9:0] e, got;
    if (rst) begin
      exp_q.delete();
      model_cnt = 0;
      exp_done = 0;
      exp_kerr = 0;
      prev_stall = 0;
    end else begin
      got = {m_user, m_last, m_data};
      pend = exp_q.size() - (m_valid ? 1 : 0);
      chk("s_ready", s_ready, pend == 0 || (pend == 1 && (!m_valid || m_ready)));
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_hold", got, prev_out);
      end
      chk("frame_done", f_done, exp_done);
      if (exp_done) chk("frame_len", f_len, exp_len);
      if (f_done) begin
        done_cnt++;
        last_len = f_len;
      end
      chk("keep_error", k_err, exp_kerr);
      if (k_err) kerr_cnt++;
      exp_done = 0;
      if (m_valid && m_ready) begin
        e = got;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_byte: got unexpected %0h expected none", got);
        end else begin
          e = exp_q.pop_front();
          chk("out_byte", got, e);
        end
        log_q.push_back(got);
        hs_cyc.push_back(cyc);
        model_cnt++;
        if (e[8]) begin
          exp_done = 1;
          exp_len = model_cnt;
          model_cnt = 0;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_out = got;
      exp_kerr = s_valid && s_ready && s_keep == '0;
      if (s_valid && s_ready) expand(s_data, s_keep, s_last, s_user);
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input logic [UW-1:0] u);
    bit ok;
    s_data = d; s_keep = k; s_last = l; s_user = u; s_valid = 1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      if (t > 1000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got no s_axis_tready expected within 1000 cycles");
        break;
      end
    end
    s_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || m_valid) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 2000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d bytes pending expected 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_q.delete();
    hs_cyc.delete();
    done_cnt = 0;
    kerr_cnt = 0;
  endtask

  task automatic check_log(input string name, input logic [9:0] e[$]);
    chk({name, "_count"}, log_q.size(), e.size());
    for (int i = 0; i < e.size() && i < log_q.size(); i++) chk(name, log_q[i], e[i]);
  endtask

  initial begin
    logic [9:0] e[$];
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_data", {m_user, m_last, m_data}, 0);
    chk("rst_status", {f_len, f_done, k_err}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    clear_log();
    send(32'h44332211, 4'hF, 0, 0);
    send(32'h88776655, 4'hF, 0, 0);
    send(32'h0000AA99, 4'h3, 1, 0);
    drain();
    e = '{10'h011, 10'h022, 10'h033, 10'h044, 10'h055, 10'h066, 10'h077, 10'h088, 10'h099, 10'h1AA};
    check_log("t1_bytes", e);
    chk("t1_span", hs_cyc[hs_cyc.size()-1] - hs_cyc[0], 9);
    chk("t1_done", done_cnt, 1);
    chk("t1_len", last_len, 10);
    clear_log();
    send(32'h01, 4'h1, 1, 0);
    send(32'h02, 4'h1, 1, 0);
    send(32'h03, 4'h1, 1, 0);
    drain();
    e = '{10'h101, 10'h102, 10'h103};
    check_log("t2_bytes", e);
    chk("t2_span", hs_cyc[hs_cyc.size()-1] - hs_cyc[0], 2);
    chk("t2_done", done_cnt, 3);
    chk("t2_len", last_len, 1);
    clear_log();
    send(32'hDDCCBBAA, 4'b1010, 1, 1);
    drain();
    e = '{10'h0BB, 10'h3DD};
    check_log("t3_bytes", e);
    chk("t3_len", last_len, 2);
    clear_log();
    pat = 0;
    rmode = 2;
    send(32'h44332211, 4'hF, 0, 0);
    send(32'h88776655, 4'hF, 1, 0);
    drain();
    rmode = 0;
    e = '{10'h011, 10'h022, 10'h033, 10'h044, 10'h055, 10'h066, 10'h077, 10'h188};
    check_log("t4_bytes", e);
    chk("t4_len", last_len, 8);
    clear_log();
    send(32'h44332211, 4'hF, 0, 0);
    send(32'h12345678, 4'h0, 0, 0);
    send(32'h000000EE, 4'h0, 1, 0);
    drain();
    e = '{10'h011, 10'h022, 10'h033, 10'h044, 10'h3EE};
    check_log("t5_bytes", e);
    chk("t5_kerr", kerr_cnt, 2);
    chk("t5_len", last_len, 5);
    send(32'h0D0C0B0A, 4'hF, 1, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("t6_rst_valid", m_valid, 0);
    chk("t6_rst_status", {f_len, f_done}, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    clear_log();
    send(32'h04030201, 4'hF, 1, 0);
    drain();
    e = '{10'h001, 10'h002, 10'h003, 10'h104};
    check_log("t6_bytes", e);
    chk("t6_done", done_cnt, 1);
    chk("t6_len", last_len, 4);
    rmode = 1;
    for (int n = 0; n < 400; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send($urandom, ($urandom_range(0, 7) == 0) ? 4'h0 : KW'($urandom), $urandom_range(0, 3) == 0, UW'($urandom));
    end
    drain();
    rmode = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected within time limit");
    $fatal(1, "watchdog");
  end
endmodule
